imm_extend_stage: RTL and testbench

//  Registered, parametrised immediate extender for the MIPS pipeline ID stage.
//  - Widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI), branch-offset.
//  - Carries a tag (destination/PC index) alongside the result.
//  - Valid/ready handshake on both sides, with a 2-entry skid buffer so upstream stalls are never combinational.
//  - Pipeline flush input.

---
 rtl/imm_extend_if.sv | 28 ++
 rtl/imm_extend_stage.sv | 118 +++++++++++
 tb/tb_imm_extend_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/imm_extend_if.sv
// Handshake bundle for the immediate extender: upstream offer side and downstream result side.
interface imm_extend_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
);
    logic             InValid;
    logic             InReady;
    logic [IN_W-1:0]  Imm;
    logic [1:0]       Mode;
    logic [TAG_W-1:0] InTag;
    logic             OutValid;
    logic             OutReady;
    logic [OUT_W-1:0] Out;
    logic [TAG_W-1:0] OutTag;

    // Driver of the offers and consumer of the results
    modport master (
        output InValid, Imm, Mode, InTag, OutReady,
        input  InReady, OutValid, Out, OutTag
    );

    // The extender itself
    modport slave (
        input  InValid, Imm, Mode, InTag, OutReady,
        output InReady, OutValid, Out, OutTag
    );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate extender for the ID stage with a 2-entry skid buffer.
// Entries are extended on accept and stored already widened.
module imm_extend_stage #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHIFT = 2,
    parameter int unsigned TAG_W    = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Flush,
    imm_extend_if.slave  bus
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    entry_t           m_q, m_d;
    entry_t           s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             deliver;
    logic [OUT_W-1:0] sign_ext;
    entry_t           in_entry;

    // Widen the offered immediate according to Mode
    always_comb begin
        sign_ext     = OUT_W'(signed'(bus.Imm));
        in_entry.tag = bus.InTag;
        unique case (bus.Mode)
            2'b00:   in_entry.data = sign_ext;
            2'b01:   in_entry.data = OUT_W'(bus.Imm);
            2'b10:   in_entry.data = OUT_W'(bus.Imm) << EXT_W;
            default: in_entry.data = sign_ext << BR_SHIFT;
        endcase
    end

    assign accept  = bus.InValid & in_ready_q;
    assign deliver = out_valid_q & bus.OutReady;

    // Occupancy FSM: M holds the head entry, S catches one entry while M stalls
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_d     = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    m_d = in_entry;
                end else if (accept) begin
                    s_d     = in_entry;
                    state_d = ST_FULL;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush discards everything, including an accept in the same cycle
        if (Flush) begin
            state_d = ST_EMPTY;
            m_d     = '0;
            s_d     = '0;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.InReady  = in_ready_q;
    assign bus.OutValid = out_valid_q;
    assign bus.Out      = m_q.data;
    assign bus.OutTag   = m_q.tag;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed and randomized bench for imm_extend_stage against a FIFO-of-values reference model.
module tb_imm_extend_stage;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic Reset;
    logic Flush;

    int   total;
    int   bad;
    int   n_del;
    bit   zero_out;
    exp_t q[$];

    imm_extend_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

    imm_extend_stage #(
        .IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)
    ) dut (
        .Clk   (clk),
        .Reset (Reset),
        .Flush (Flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic definition of the four extension modes
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(longint'(imm));
            2'd2:    return 32'(longint'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model
    task automatic cyc(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic ordy, input logic fl, input logic rst);
        bit   acc;
        bit   del;
        exp_t e;
        bus.InValid  = v;
        bus.Imm      = imm;
        bus.Mode     = mode;
        bus.InTag    = tag;
        bus.OutReady = ordy;
        Flush        = fl;
        Reset        = rst;
        chk("out_valid", 64'(bus.OutValid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.InReady), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_data", 64'(bus.Out), 64'(q[0].data));
            chk("out_tag", 64'(bus.OutTag), 64'(q[0].tag));
        end else if (zero_out) begin
            chk("out_zero", 64'(bus.Out), 64'(0));
            chk("tag_zero", 64'(bus.OutTag), 64'(0));
        end
        acc = v && (q.size() < 2);
        del = ordy && (q.size() > 0);
        e.tag  = tag;
        e.data = ref_ext(imm, mode);
        @(posedge clk);
        #1;
        if (rst || fl) begin
            q.delete();
            zero_out = 1'b1;
        end else begin
            if (del) begin
                void'(q.pop_front());
                n_del++;
            end
            if (acc) begin
                q.push_back(e);
                zero_out = 1'b0;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_del = 0;
        bus.InValid  = 1'b0;
        bus.Imm      = '0;
        bus.Mode     = '0;
        bus.InTag    = '0;
        bus.OutReady = 1'b0;
        Flush        = 1'b0;
        Reset        = 1'b1;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        zero_out = 1'b1;
        chk("rst_out_valid", 64'(bus.OutValid), 64'(0));
        chk("rst_out", 64'(bus.Out), 64'(0));
        chk("rst_out_tag", 64'(bus.OutTag), 64'(0));
        chk("rst_in_ready", 64'(bus.InReady), 64'(1));

        // Sign mode, latency 1
        cyc(1'b1, 16'h8001, 2'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("sign_out", 64'(bus.Out), 64'h0000_0000_FFFF_8001);
        chk("sign_tag", 64'(bus.OutTag), 64'(3));

        // Zero, upper and branch modes in order
        cyc(1'b1, 16'hFFFE, 2'd1, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("zero_out", 64'(bus.Out), 64'h0000_0000_0000_FFFE);
        cyc(1'b1, 16'hFFFE, 2'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("upper_out", 64'(bus.Out), 64'h0000_0000_FFFE_0000);
        cyc(1'b1, 16'hFFFE, 2'd3, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("branch_out", 64'(bus.Out), 64'h0000_0000_FFFF_FFF8);
        cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Stall: three offers, only two fit
        cyc(1'b1, 16'h1234, 2'd1, 5'd10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h8765, 2'd0, 5'd11, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", 64'(bus.InReady), 64'(0));
        cyc(1'b1, 16'h5555, 2'd2, 5'd12, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_out", 64'(bus.Out), 64'h0000_0000_0000_1234);
        cyc(1'b0, 16'h0, 2'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("stall_second", 64'(bus.Out), 64'h0000_0000_FFFF_8765);
        chk("stall_second_tag", 64'(bus.OutTag), 64'(11));
        cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("stall_drained", 64'(bus.OutValid), 64'(0));

        // Streaming: one result per cycle
        n_del = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'(i * 16'h1111), 2'(i), 5'(i + 16), 1'b1, 1'b0, 1'b0);
            chk("stream_valid", 64'(bus.OutValid), 64'(1));
        end
        cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_count", 64'(n_del), 64'(8));

        // Flush from FULL with a coincident offer
        cyc(1'b1, 16'hAAAA, 2'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hBBBB, 2'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hCCCC, 2'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(bus.OutValid), 64'(0));
        chk("flush_in_ready", 64'(bus.InReady), 64'(1));
        chk("flush_out", 64'(bus.Out), 64'(0));
        repeat (3) cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(3) != 0), 16'($urandom), 2'($urandom), 5'($urandom),
                1'($urandom_range(2) != 0), 1'($urandom_range(40) == 0), 1'($urandom_range(90) == 0));
        end
        repeat (3) cyc(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
